// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for C = M^E mod N, driving an external modular multiplier.
// Optional build macro RSA_SKIP_LEADING_ZEROS_EN skips the squarings of result=1 ahead of the first set exponent bit.
module rsa_exp_ctrl #(
    parameter int DATA_W = 10,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    input  logic              start,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [DATA_W-1:0] message,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_opa,
    output logic [DATA_W-1:0] mul_opb,
    input  logic              mul_eoc,
    input  logic [DATA_W-1:0] mul_result,
    output logic              busy,
    output logic              eoc,
    output logic [DATA_W-1:0] result
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SQ_REQ,
        SQ_WAIT,
        MUL_REQ,
        MUL_WAIT,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [DATA_W-1:0] msg_q, msg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              step_bit;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
    // Position of the most significant set bit; seen_one stops the scan at the first 1.
    function automatic logic [IDX_W-1:0] lead_one(input logic [EXP_W-1:0] e);
        logic seen_one;
        lead_one = '0;
        seen_one = 1'b0;
        for (int i = EXP_W - 1; i >= 0; i--) begin
            if (!seen_one && e[i]) begin
                lead_one = IDX_W'(i);
                seen_one = 1'b1;
            end
        end
    endfunction
`endif

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            msg_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            msg_q    <= msg_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
        end
    end

    // NOTE: every signal gets a hold default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        msg_d    = msg_q;
        idx_d    = idx_q;
        result_d = result_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        step_bit = 1'b0;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_d    = exponent;
                        msg_d    = message;
                        result_d = DATA_W'(1);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
                        if (exponent == '0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = lead_one(exponent);
                            state_d = MUL_REQ;
                        end
`else
                        idx_d   = IDX_W'(EXP_W - 1);
                        state_d = SQ_REQ;
`endif
                    end
                end
                SQ_REQ:  state_d = SQ_WAIT;
                SQ_WAIT: begin
                    if (mul_eoc) begin
                        result_d = mul_result;
                        if (exp_q[idx_q]) state_d = MUL_REQ;
                        else              step_bit = 1'b1;
                    end
                end
                MUL_REQ: state_d = MUL_WAIT;
                MUL_WAIT: begin
                    if (mul_eoc) begin
                        result_d = mul_result;
                        step_bit = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (step_bit) begin
            if (idx_q == '0) begin
                state_d = DONE;
            end else begin
                idx_d   = idx_q - 1'b1;
                state_d = SQ_REQ;
            end
        end

        // Operands are loaded on entry to a request state so they are valid alongside mul_start.
        if (state_d == SQ_REQ && state_q != SQ_REQ) begin
            opa_d = result_d;
            opb_d = result_d;
        end else if (state_d == MUL_REQ && state_q != MUL_REQ) begin
            opa_d = result_d;
            opb_d = msg_d;
        end
    end

    // Pulses come straight from the state, so a pulse masked by en=0 reappears when en returns.
    always_comb begin
        mul_start = 1'b0;
        eoc       = 1'b0;
        busy      = (state_q != IDLE);
        mul_opa   = opa_q;
        mul_opb   = opb_q;
        result    = result_q;
        if (en) begin
            mul_start = (state_q == SQ_REQ) || (state_q == MUL_REQ);
            eoc       = (state_q == DONE);
        end
    end

endmodule
